lift_door_ctrl: RTL and testbench
=================================

// Module: lift_door_ctrl
// PURPOSE
//  Door-cycle controller for one lift car; drives the door motor and the dwell timer.
//  Sits directly upstream of the timer: owns its enable (o_timer_en -> timer i_enable) and consumes o_done.
//  Opens on arrival or an open request, dwells until the timer expires, then closes.
//  Reverses on obstruction or an open request; o_door_closed gates car motion in the lift FSM.
// PARAMETERS
//  TRAVEL_CYCLES  8  clock cycles for full door travel, open<->closed (>=2)
//  MAX_REOPEN     3  obstruction reversals per cycle before o_alarm asserts (>=1)
// PORTS
//  i_clock        in   1  single system clock; all logic on posedge
//  i_rst          in   1  synchronous, active-high reset
//  i_arrive       in   1  car stopped at a floor; requests a door cycle (level or pulse)
//  i_open_btn     in   1  door-open request (car or landing button)
//  i_close_btn    in   1  door-close request
//  i_obstruct     in   1  obstruction sensor; high = blocked
//  i_timer_done   in   1  dwell expired, from timer o_done
//  o_timer_en     out  1  to timer i_enable; low clears the timer
//  o_motor_open   out  1  drive door toward open
//  o_motor_close  out  1  drive door toward closed
//  o_door_closed  out  1  door fully closed; car may move
//  o_door_state   out  2  00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING
//  o_alarm        out  1  reopen limit reached; held until CLOSED is re-entered
// BEHAVIOUR
//  - All outputs registered. They change only on posedge i_clock and reflect the current state.
//  - Reset values: state=CLOSED, pos=0, reopen_cnt=0, o_door_closed=1, o_door_state=00,
//    and all other outputs 0. Reset mid-operation forces this on the next edge with no motor overrun.
//  - pos: door position, 0=closed, TRAVEL_CYCLES=open; width $clog2(TRAVEL_CYCLES+1).
//    pos never wraps; it saturates at 0 and at TRAVEL_CYCLES.
//  - CLOSED: i_arrive|i_open_btn -> OPENING.
//      o_door_closed drops on that same edge.
//      i_close_btn and i_obstruct are ignored.
//  - OPENING: o_motor_open=1; pos+1 per cycle.
//      pos reaching TRAVEL_CYCLES -> OPEN, so a full open takes exactly TRAVEL_CYCLES cycles.
//      All requests are ignored.
//  - OPEN: o_timer_en=1. Priority per cycle is obstruct > open_btn > close_btn > timer_done.
//      i_obstruct|i_open_btn: o_timer_en=0 for exactly one cycle, then 1 (dwell restart).
//      i_close_btn: -> CLOSING next edge.
//      i_timer_done while o_timer_en=1: -> CLOSING next edge.
//      i_timer_done while o_timer_en=0 is ignored.
//  - CLOSING: o_motor_close=1; pos-1 per cycle. pos reaching 0 -> CLOSED,
//      which clears reopen_cnt and o_alarm.
//      i_obstruct: -> OPENING from the current pos, reopen_cnt+1 (saturating);
//        o_alarm=1 once reopen_cnt==MAX_REOPEN.
//      i_open_btn|i_arrive without i_obstruct: -> OPENING, reopen_cnt unchanged.
//      A reversal takes TRAVEL_CYCLES-pos cycles to reach OPEN.
//  - o_alarm is advisory only; obstruction always reverses the door, even with o_alarm high.
//  - Motor outputs are mutually exclusive. A direction change has no dead cycle.
//  - Simultaneous close_btn and obstruct in OPEN: obstruct wins, dwell restarts.
//  - i_timer_done outside OPEN is ignored.
// TESTING (TRAVEL_CYCLES=4, MAX_REOPEN=2)
//  - Reset 2 cycles -> o_door_closed=1, o_door_state=00, motors=0, o_timer_en=0, o_alarm=0.
//  - i_arrive 1 cycle -> state 01 for exactly 4 cycles with o_motor_open=1, then state 10 and o_timer_en=1.
//  - In OPEN, pulse i_timer_done -> CLOSING 4 cycles, then CLOSED; o_door_closed=1.
//  - In OPEN, i_open_btn 1 cycle -> o_timer_en low exactly 1 cycle, state stays 10.
//  - In OPEN, i_close_btn -> CLOSING on the next edge without waiting for i_timer_done.
//  - CLOSING after 1 cycle (pos=3), i_obstruct -> OPENING lasts 1 cycle.
//      A second obstruction -> o_alarm=1.
//      Clean close -> o_alarm=0 at CLOSED.
//  - i_rst pulsed mid-OPENING -> next edge CLOSED, pos=0, o_motor_open=0.

Source files
------------

// File: rtl/lift_door_ctrl_if.sv
// Signal bundle between the lift car logic and its door-cycle controller.
// The master side issues requests and the dwell-timer result; the slave side drives the motor and status.
interface lift_door_ctrl_if;
  logic       i_arrive;
  logic       i_open_btn;
  logic       i_close_btn;
  logic       i_obstruct;
  logic       i_timer_done;
  logic       o_timer_en;
  logic       o_motor_open;
  logic       o_motor_close;
  logic       o_door_closed;
  logic [1:0] o_door_state;
  logic       o_alarm;

  modport master (
    output i_arrive, i_open_btn, i_close_btn, i_obstruct, i_timer_done,
    input  o_timer_en, o_motor_open, o_motor_close, o_door_closed, o_door_state, o_alarm
  );

  modport slave (
    input  i_arrive, i_open_btn, i_close_btn, i_obstruct, i_timer_done,
    output o_timer_en, o_motor_open, o_motor_close, o_door_closed, o_door_state, o_alarm
  );
endinterface

// File: rtl/lift_door_ctrl.sv
// Door-cycle controller for one lift car: opens, dwells on the external timer, closes,
// and reverses on obstruction or an open request. Every output is a registered function of the new state.
module lift_door_ctrl #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int MAX_REOPEN    = 3
) (
  input logic             i_clock,
  input logic             i_rst,
  lift_door_ctrl_if.slave door
);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'b00,
    ST_OPENING = 2'b01,
    ST_OPEN    = 2'b10,
    ST_CLOSING = 2'b11
  } state_t;

  localparam int POS_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int CNT_W = $clog2(MAX_REOPEN + 1);

  localparam logic [POS_W-1:0] POS_OPEN = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(TRAVEL_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_REOPEN);

  state_t           state;
  state_t           state_n;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_n;
  logic [CNT_W-1:0] reopen_cnt;
  logic [CNT_W-1:0] reopen_cnt_n;
  logic             alarm_n;
  logic             restart;

  logic             timer_en_q;
  logic             motor_open_q;
  logic             motor_close_q;
  logic             door_closed_q;
  logic [1:0]       door_state_q;
  logic             alarm_q;

  // Next-state logic. A reversal keeps the current position so the door
  // only has to travel back the distance it already closed.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch);
    // blocking assignments here, non-blocking only in the clocked block.
    state_n      = state;
    pos_n        = pos;
    reopen_cnt_n = reopen_cnt;
    alarm_n      = alarm_q;
    restart      = 1'b0;

    case (state)
      ST_CLOSED: begin
        if (door.i_arrive || door.i_open_btn) begin
          state_n = ST_OPENING;
        end
      end

      ST_OPENING: begin
        if (pos >= POS_LAST) begin
          pos_n   = POS_OPEN;
          state_n = ST_OPEN;
        end else begin
          pos_n = pos + 1'b1;
        end
      end

      ST_OPEN: begin
        // Obstruction and open requests outrank a close request; a timer
        // expiry only counts while the timer was actually enabled.
        if (door.i_obstruct || door.i_open_btn) begin
          restart = 1'b1;
        end else if (door.i_close_btn) begin
          state_n = ST_CLOSING;
        end else if (door.i_timer_done && timer_en_q) begin
          state_n = ST_CLOSING;
        end
      end

      ST_CLOSING: begin
        if (door.i_obstruct) begin
          state_n = ST_OPENING;
          if (reopen_cnt != CNT_MAX) begin
            reopen_cnt_n = reopen_cnt + 1'b1;
          end
          if (reopen_cnt_n == CNT_MAX) begin
            alarm_n = 1'b1;
          end
        end else if (door.i_open_btn || door.i_arrive) begin
          state_n = ST_OPENING;
        end else if (pos <= POS_ONE) begin
          pos_n        = '0;
          state_n      = ST_CLOSED;
          reopen_cnt_n = '0;
          alarm_n      = 1'b0;
        end else begin
          pos_n = pos - 1'b1;
        end
      end

      default: begin
        state_n = ST_CLOSED;
        pos_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      state         <= ST_CLOSED;
      pos           <= '0;
      reopen_cnt    <= '0;
      alarm_q       <= 1'b0;
      timer_en_q    <= 1'b0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      door_closed_q <= 1'b1;
      door_state_q  <= ST_CLOSED;
    end else begin
      state         <= state_n;
      pos           <= pos_n;
      reopen_cnt    <= reopen_cnt_n;
      alarm_q       <= alarm_n;
      timer_en_q    <= (state_n == ST_OPEN) && !restart;
      motor_open_q  <= (state_n == ST_OPENING);
      motor_close_q <= (state_n == ST_CLOSING);
      door_closed_q <= (state_n == ST_CLOSED);
      door_state_q  <= state_n;
    end
  end

  assign door.o_timer_en    = timer_en_q;
  assign door.o_motor_open  = motor_open_q;
  assign door.o_motor_close = motor_close_q;
  assign door.o_door_closed = door_closed_q;
  assign door.o_door_state  = door_state_q;
  assign door.o_alarm       = alarm_q;

  a_motor_exclusive: assert property (@(posedge i_clock) disable iff (i_rst)
    !(motor_open_q && motor_close_q));

  a_pos_in_range: assert property (@(posedge i_clock) disable iff (i_rst)
    pos <= POS_OPEN);

endmodule

// File: tb/tb_lift_door_ctrl.sv
// Bench for lift_door_ctrl: a hand-derived vector table, a few multi-cycle sequences,
// then random stimulus against a position/direction model of the door.
module tb_lift_door_ctrl;

  localparam int T = 4;
  localparam int M = 2;

  // Packed expectation: {state[1:0], closed, motor_open, motor_close, timer_en, alarm}
  localparam bit [6:0] E_CLOSED    = 7'b00_1_0_0_0_0;
  localparam bit [6:0] E_OPENING   = 7'b01_0_1_0_0_0;
  localparam bit [6:0] E_OPEN      = 7'b10_0_0_0_1_0;
  localparam bit [6:0] E_OPEN_HOLD = 7'b10_0_0_0_0_0;
  localparam bit [6:0] E_CLOSING   = 7'b11_0_0_1_0_0;
  localparam bit [6:0] A           = 7'b00_0_0_0_0_1;

  typedef struct {
    bit       rst;
    bit       arrive;
    bit       open_btn;
    bit       close_btn;
    bit       obstruct;
    bit       done;
    bit [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lift_door_ctrl_if ifc ();

  lift_door_ctrl #(
    .TRAVEL_CYCLES(T),
    .MAX_REOPEN   (M)
  ) dut (
    .i_clock(clk),
    .i_rst  (rst),
    .door   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Door model: position plus direction of travel (+1 opening, -1 closing, 0 at rest).
  int m_pos    = 0;
  int m_dir    = 0;
  int m_reopen = 0;
  bit m_alarm  = 1'b0;
  bit m_ten    = 1'b0;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit a, input bit o, input bit c,
                            input bit ob, input bit d);
    bit restart;
    restart = 1'b0;
    if (r) begin
      m_pos = 0; m_dir = 0; m_reopen = 0; m_alarm = 1'b0; m_ten = 1'b0;
      return;
    end
    if (m_dir == 1) begin
      m_pos = (m_pos + 1 > T) ? T : m_pos + 1;
      if (m_pos == T) m_dir = 0;
    end else if (m_dir == -1) begin
      if (ob) begin
        m_dir    = 1;
        m_reopen = (m_reopen + 1 > M) ? M : m_reopen + 1;
        if (m_reopen == M) m_alarm = 1'b1;
      end else if (o || a) begin
        m_dir = 1;
      end else begin
        m_pos = m_pos - 1;
        if (m_pos == 0) begin
          m_dir = 0; m_reopen = 0; m_alarm = 1'b0;
        end
      end
    end else if (m_pos == 0) begin
      if (a || o) m_dir = 1;
    end else begin
      restart = ob || o;
      if (!restart && (c || (d && m_ten))) m_dir = -1;
    end
    m_ten = (m_dir == 0) && (m_pos == T) && !restart;
  endtask

  function automatic logic [6:0] model_pack();
    logic [1:0] st;
    if (m_dir == 1)       st = 2'b01;
    else if (m_dir == -1) st = 2'b11;
    else if (m_pos == 0)  st = 2'b00;
    else                  st = 2'b10;
    return {st, st == 2'b00, m_dir == 1, m_dir == -1, m_ten, m_alarm};
  endfunction

  function automatic logic [6:0] dut_pack();
    return {ifc.o_door_state, ifc.o_door_closed, ifc.o_motor_open,
            ifc.o_motor_close, ifc.o_timer_en, ifc.o_alarm};
  endfunction

  task automatic step(input bit r, input bit a, input bit o, input bit c,
                      input bit ob, input bit d);
    rst              = r;
    ifc.i_arrive     = a;
    ifc.i_open_btn   = o;
    ifc.i_close_btn  = c;
    ifc.i_obstruct   = ob;
    ifc.i_timer_done = d;
    model_step(r, a, o, c, ob, d);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, output int n);
    n = 0;
    while (ifc.o_door_state !== target && n < budget) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
    end
  endtask

  task automatic add(input bit r, input bit a, input bit o, input bit c,
                     input bit ob, input bit d, input bit [6:0] e);
    vq.push_back('{r, a, o, c, ob, d, e});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;

    ifc.i_arrive     = 1'b0;
    ifc.i_open_btn   = 1'b0;
    ifc.i_close_btn  = 1'b0;
    ifc.i_obstruct   = 1'b0;
    ifc.i_timer_done = 1'b0;

    //  r  a  o  c  ob d   expected
    add(1, 0, 0, 0, 0, 0, E_CLOSED);
    add(1, 1, 0, 0, 0, 0, E_CLOSED);
    add(0, 0, 0, 0, 0, 1, E_CLOSED);          // timer_done ignored when closed
    add(0, 0, 0, 1, 1, 0, E_CLOSED);          // close/obstruct ignored when closed
    add(0, 1, 0, 0, 0, 0, E_OPENING);         // pos 0
    add(0, 0, 0, 1, 0, 0, E_OPENING);         // pos 1, requests ignored
    add(0, 0, 0, 0, 1, 0, E_OPENING);         // pos 2
    add(0, 0, 1, 0, 0, 1, E_OPENING);         // pos 3
    add(0, 0, 0, 0, 0, 0, E_OPEN);
    add(0, 0, 0, 0, 0, 1, E_CLOSING);         // dwell expired
    add(0, 0, 0, 0, 0, 0, E_CLOSING);
    add(0, 0, 0, 0, 0, 0, E_CLOSING);
    add(0, 0, 0, 0, 0, 0, E_CLOSING);
    add(0, 0, 0, 0, 0, 0, E_CLOSED);
    add(0, 0, 1, 0, 0, 0, E_OPENING);
    add(0, 0, 0, 0, 0, 0, E_OPENING);
    add(0, 0, 0, 0, 0, 0, E_OPENING);
    add(0, 0, 0, 0, 0, 0, E_OPENING);
    add(0, 0, 0, 0, 0, 0, E_OPEN);
    add(0, 0, 1, 0, 0, 0, E_OPEN_HOLD);       // dwell restart
    add(0, 0, 0, 0, 0, 0, E_OPEN);
    add(0, 0, 0, 1, 1, 0, E_OPEN_HOLD);       // obstruct beats close
    add(0, 0, 0, 0, 0, 1, E_OPEN);            // done ignored while timer disabled
    add(0, 0, 0, 1, 0, 0, E_CLOSING);         // pos 4
    add(0, 0, 0, 0, 0, 0, E_CLOSING);         // pos 3
    add(0, 0, 0, 0, 1, 0, E_OPENING);         // first reversal
    add(0, 0, 0, 0, 0, 0, E_OPEN);
    add(0, 0, 0, 1, 0, 0, E_CLOSING);
    add(0, 0, 0, 0, 0, 0, E_CLOSING);
    add(0, 0, 0, 0, 1, 0, E_OPENING | A);     // second reversal raises alarm
    add(0, 0, 0, 0, 0, 0, E_OPEN | A);
    add(0, 0, 0, 0, 0, 1, E_CLOSING | A);
    add(0, 0, 0, 0, 0, 0, E_CLOSING | A);
    add(0, 0, 0, 0, 0, 0, E_CLOSING | A);
    add(0, 0, 0, 0, 0, 0, E_CLOSING | A);
    add(0, 0, 0, 0, 0, 0, E_CLOSED);          // clean close clears alarm
    add(0, 1, 0, 0, 0, 0, E_OPENING);
    add(0, 0, 0, 0, 0, 0, E_OPENING);
    add(1, 1, 0, 0, 0, 0, E_CLOSED);          // reset mid-opening
    add(0, 0, 0, 0, 0, 0, E_CLOSED);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].arrive, vq[i].open_btn, vq[i].close_btn,
           vq[i].obstruct, vq[i].done);
      check($sformatf("vec%0d", i), 32'(dut_pack()), 32'(vq[i].exp));
    end

    // Full open takes exactly T cycles.
    step(0, 1, 0, 0, 0, 0);
    wait_state(2'b10, 20, n);
    check("open_latency", n, T);

    // Arrive during closing reverses without counting toward the alarm.
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("arrive_reverse", 32'(dut_pack()), 32'(E_OPENING));
    step(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= M + 1; k++) begin
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      check($sformatf("obstruct%0d", k), 32'(dut_pack()),
            32'(E_OPENING | ((k >= M) ? A : 7'b0)));
      step(0, 0, 0, 0, 0, 0);
    end

    // Clean close after the alarm: exactly T closing cycles, alarm cleared.
    step(0, 0, 0, 0, 0, 1);
    wait_state(2'b00, 20, n);
    check("close_latency", n, T);
    check("alarm_cleared", 32'(dut_pack()), 32'(E_CLOSED));

    // Random traffic against the model.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0);
      check("rand", 32'(dut_pack()), 32'(model_pack()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
